// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering and a valid/ready instruction stream to decode.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing requests and buffering responses
// HALTING | HALT buffered; draining FIFO and outstanding responses
// DONE    | halt drained; done held until next start
module fetch_unit #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          INSTR_WIDTH = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   busy,
    output logic                   done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTING, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      discard_q, discard_d;

    logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem   [FIFO_DEPTH];

    logic            active, req_fire, rsp_dec, push, pop;
    logic [CNT_W:0]  credit;

    always_comb begin
        active         = (state_q == S_FETCH) || (state_q == S_HALTING);
        credit         = {1'b0, count_q} + {1'b0, outst_q};
        imem_req_valid = (state_q == S_FETCH) && !redirect_valid && (credit < DEPTH_W);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_dec        = active && imem_rsp_valid && (outst_q != '0);
        instr_valid    = (count_q != '0) && !redirect_valid;
        pop            = instr_valid && instr_ready;
        instr          = (count_q != '0) ? data_mem[rd_ptr_q] : '0;
        instr_pc       = (count_q != '0) ? pc_mem[rd_ptr_q] : '0;
        busy           = active;
        done           = (state_q == S_DONE);

        state_d   = state_q;
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        discard_d = discard_q;
        push      = 1'b0;
        outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_dec);

        if (req_fire) begin
            pc_d = pc_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = start_pc;
                    rsp_pc_d  = start_pc;
                    discard_d = '0;
                end
            end
            S_FETCH, S_HALTING: begin
                if (redirect_valid) begin
                    // responses still in flight belong to the abandoned path
                    state_d   = S_FETCH;
                    pc_d      = redirect_pc;
                    rsp_pc_d  = redirect_pc;
                    discard_d = outst_d;
                    count_d   = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                end else begin
                    if (rsp_dec) begin
                        if (discard_q != '0) begin
                            discard_d = discard_q - 1'b1;
                        end else if (state_q == S_FETCH) begin
                            push     = 1'b1;
                            rsp_pc_d = rsp_pc_q + 1'b1;
                            if (imem_rsp_data[INSTR_WIDTH-1 -: 4] == HALT_OPCODE) begin
                                state_d = S_HALTING;
                            end
                        end
                    end
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                    if (state_q == S_HALTING && count_q == '0 && outst_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rsp_pc_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// of configurable latency and request back-pressure.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = 8'h00;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = 16'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH(8), .INSTR_WIDTH(16), .FIFO_DEPTH(4), .HALT_OPCODE(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_fire = 0;
    int last_due = 0;
    bit ready_toggle = 1'b0;
    int lat_fixed = 1;
    bit halt_en = 1'b0;
    logic [7:0] halt_pc = 8'h00;
    logic [7:0] q_addr[$];
    int         q_due[$];
    logic [7:0]  rx_pc[$];
    logic [15:0] rx_data[$];

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (halt_en && a == halt_pc) return 16'hF000;
        return {4'h3, a[3:0] ^ 4'h5, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory: drives at the falling edge, samples the request 3 units later.
    always @(negedge clk) begin
        int lat;
        int due;
        cyc++;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            last_due = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0;
            imem_req_ready = 1'b0;
        end else begin
            imem_req_ready = ready_toggle ? cyc[0] : 1'b1;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 16'h0;
            end
            #3;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                lat = (lat_fixed > 0) ? lat_fixed : 1 + (n_fire % 3);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                q_addr.push_back(imem_req_addr);
                q_due.push_back(due);
                n_fire++;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst_n && instr_valid && instr_ready) begin
            rx_pc.push_back(instr_pc);
            rx_data.push_back(instr);
            chk("rx_data", 32'(instr), 32'(mem_word(instr_pc)));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        rx_pc.delete();
        rx_data.delete();
        n_fire = 0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Streaming from 0x10 with one-cycle memory
        do_reset();
        lat_fixed = 1; instr_ready = 1'b1;
        start = 1'b1; start_pc = 8'h10;
        step(1); start = 1'b0;
        step(3);
        for (int i = 0; i < 8; i++) begin
            #1 chk("t1_no_gap", instr_valid, 1);
            step(1);
        end
        chk("t1_rx_count_ge6", 32'(rx_pc.size() >= 6), 1);
        for (int i = 0; i < 6; i++) chk("t1_pc_order", rx_pc[i], 32'h10 + i);

        // Decoder stall: credit limit then release
        do_reset();
        lat_fixed = 1; instr_ready = 1'b0;
        start = 1'b1; start_pc = 8'h20;
        step(1); start = 1'b0;
        step(8);
        #1;
        chk("t2_fires_capped", n_fire, 4);
        chk("t2_req_valid_low", imem_req_valid, 0);
        chk("t2_instr_valid", instr_valid, 1);
        chk("t2_head_pc", instr_pc, 32'h20);
        instr_ready = 1'b1;
        step(14);
        chk("t2_rx_count_ge10", 32'(rx_pc.size() >= 10), 1);
        for (int i = 0; i < 10; i++) chk("t2_pc_order", rx_pc[i], 32'h20 + i);

        // Toggling request ready and 1..3 cycle latency
        do_reset();
        ready_toggle = 1'b1; lat_fixed = 0; instr_ready = 1'b1;
        start = 1'b1; start_pc = 8'h30;
        step(1); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 chk("t3_pc_on_handshake", imem_req_addr, (32'h30 + n_fire) & 32'hFF);
            step(1);
        end
        step(6);
        chk("t3_rx_count_ge6", 32'(rx_pc.size() >= 6), 1);
        for (int i = 0; i < 6; i++) chk("t3_pc_order", rx_pc[i], 32'h30 + i);
        ready_toggle = 1'b0; lat_fixed = 1;

        // Redirect with two buffered and two in flight
        do_reset();
        lat_fixed = 3; instr_ready = 1'b0;
        start = 1'b1; start_pc = 8'h50;
        step(1); start = 1'b0;
        step(4);
        #1;
        chk("t4_pre_instr_valid", instr_valid, 1);
        chk("t4_pre_req_valid", imem_req_valid, 0);
        step(1);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        #1;
        chk("t4_redir_instr_valid", instr_valid, 0);
        chk("t4_redir_req_valid", imem_req_valid, 0);
        step(1);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        chk("t4_flushed", instr_valid, 0);
        chk("t4_req_resume", imem_req_valid, 1);
        chk("t4_req_addr", imem_req_addr, 32'h40);
        step(6);
        chk("t4_rx_count_ge2", 32'(rx_pc.size() >= 2), 1);
        chk("t4_first_pc", rx_pc[0], 32'h40);
        chk("t4_second_pc", rx_pc[1], 32'h41);
        lat_fixed = 1;

        // HALT at 0x05, drain, restart
        do_reset();
        lat_fixed = 1; instr_ready = 1'b1; halt_en = 1'b1; halt_pc = 8'h05;
        start = 1'b1; start_pc = 8'h02;
        step(1); start = 1'b0;
        step(2);
        #1;
        chk("t5_busy_running", busy, 1);
        chk("t5_done_running", done, 0);
        step(12);
        #1;
        chk("t5_done", done, 1);
        chk("t5_busy_low", busy, 0);
        chk("t5_req_valid_low", imem_req_valid, 0);
        chk("t5_fires", n_fire, 5);
        chk("t5_rx_count", rx_pc.size(), 4);
        chk("t5_halt_pc", rx_pc[3], 32'h05);
        chk("t5_halt_word", rx_data[3], 32'hF000);
        halt_en = 1'b0;
        start = 1'b1; start_pc = 8'h80;
        step(1); start = 1'b0;
        #1;
        chk("t5_restart_done", done, 0);
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_addr", imem_req_addr, 32'h80);

        // PC wrap, then reset mid-burst
        do_reset();
        lat_fixed = 1; instr_ready = 1'b1;
        start = 1'b1; start_pc = 8'hFE;
        step(1); start = 1'b0;
        step(5);
        #1;
        chk("t6_rx_count_ge3", 32'(rx_pc.size() >= 3), 1);
        chk("t6_pc0", rx_pc[0], 32'hFE);
        chk("t6_pc1", rx_pc[1], 32'hFF);
        chk("t6_pc2", rx_pc[2], 32'h00);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_req_valid", imem_req_valid, 0);
        chk("t6_rst_req_addr", imem_req_addr, 0);
        chk("t6_rst_instr_valid", instr_valid, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_instr_pc", instr_pc, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        #1;
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_instr_valid", instr_valid, 0);
        chk("t6_idle_req_valid", imem_req_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Generates sequential word addresses, issues requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO.
- Presents one 16-bit instruction per cycle with a valid/ready handshake to the decode stage.
- Handles start, PC redirect with flush and in-flight discard, and halt detection.

Parameters:
- ADDR_WIDTH, 8, PC / instruction-memory word-address width.
- INSTR_WIDTH, 16, instruction width; equals `DATA_WIDTH.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2.
- HALT_OPCODE, 4'hF, value of instruction[15:12] that terminates fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin fetching at start_pc (honoured in IDLE/DONE only).
- start_pc  in  ADDR_WIDTH  initial PC.
- redirect_valid  in  1  branch/jump redirect (honoured in FETCH/HALTING).
- redirect_pc  in  ADDR_WIDTH  new PC.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  word address (current PC).
- imem_rsp_valid  in  1  response valid; always accepted.
- imem_rsp_data  in  INSTR_WIDTH  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder consumes head.
- instr  out  INSTR_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  PC of head instruction.
- busy  out  1  state is FETCH or HALTING.
- done  out  1  halt drained; held until next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, FIFO empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, imem_req_addr=0, instr_valid=0, instr=0, instr_pc=0, busy=0, done=0. Reset mid-operation drops everything; responses arriving after reset deasserts while in IDLE are ignored.
- States and transitions:
  - IDLE: on start, pc<=start_pc, go to FETCH.
  - FETCH: issues requests. An accepted, non-discarded response with opcode==HALT_OPCODE moves to HALTING.
  - HALTING: no new requests. Go to DONE when FIFO empty and outstanding==0.
  - DONE: done=1. On start, clear done, load pc, go to FETCH.
- Request issue (combinational): imem_req_valid = (state==FETCH) && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH). This credit rule guarantees every response has a FIFO slot.
- On request handshake: pc<=pc+1 (wraps modulo 2^ADDR_WIDTH) and outstanding increments. imem_req_addr=pc.
- Responses return in order, at least 1 cycle after their request. Each response decrements outstanding.
  - If discard>0: drop the response and decrement discard.
  - Otherwise: write {data, pc_of_request} to the FIFO. A per-entry PC is tracked via a request-PC queue or equivalent.
  - In HALTING, responses following the HALT are dropped (the HALT entry itself is delivered).
- Output: instr_valid = FIFO non-empty && !redirect_valid. Pop on instr_valid && instr_ready. Write-to-visible latency is 1 cycle (no fall-through). Simultaneous push and pop on a full FIFO is legal.
- Redirect (FETCH or HALTING, highest priority):
  - Flush FIFO; discard <= outstanding after this cycle's request/response accounting.
  - A response arriving in the redirect cycle is dropped.
  - No request and no pop in that cycle.
  - pc<=redirect_pc; state<=FETCH (cancels HALTING).
  - Next cycle, requests resume at redirect_pc.
- Redirect in IDLE/DONE is ignored. start in FETCH/HALTING is ignored.
- Widths: outstanding and discard counters are $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Test Plan:
- Reset, start with start_pc=8'h10, memory returns 1 cycle later, instr_ready=1 → instructions for PCs 0x10,0x11,0x12… delivered in order, instr_pc matches, no gaps after pipeline fill.
- instr_ready=0 with FIFO_DEPTH=4 → at most 4 requests outstanding+buffered, imem_req_valid drops; release ready → no loss or duplication.
- imem_req_ready toggling 1/0 and variable 1–3 cycle response latency → ordered stream, pc advances only on handshake.
- Redirect to 8'h40 with 2 requests in flight and 2 buffered → both in-flight responses dropped, FIFO empty, next instr_pc=0x40.
- Word 16'hF000 at PC 0x05 → HALT delivered with instr_pc=0x05, no further requests, done=1 once drained; start restarts.
- PC 8'hFE start → requests 0xFE,0xFF,0x00; rst_n asserted mid-burst → all outputs at reset values immediately.
